ecc_op_sequencer: RTL
=====================

ECC_OP_SEQUENCER -- requirements
Module: ecc_op_sequencer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, register and core data width; TIMEOUT, 64, max cycles waiting for core_done.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 reg_enable  input  2  APB access strobe: 01 write, 10 read, 00 none; level held for the whole access phase.
REQ-006 paddr  input  2  word address: 0 CTRL, 1 DATA_IN, 2 DATA_OUT, 3 STATUS.
REQ-007 pwdata  input  DATA_WIDTH  APB write data.
REQ-008 prdata  output  DATA_WIDTH  APB read data.
REQ-009 core_start  output  1  one-cycle start pulse to the ECC core.
REQ-010 core_mode  output  2  operation: 00 encode, 01 decode, 10 correct, 11 reserved.
REQ-011 core_data_in  output  DATA_WIDTH  operand to the core.
REQ-012 core_done  input  1  one-cycle completion pulse from the core.
REQ-013 core_data_out  input  DATA_WIDTH  core result, valid with core_done.
REQ-014 core_num_err  input  2  errors detected, valid with core_done.
REQ-015 irq  output  1  level interrupt = STATUS.done AND CTRL.ie.

Function
REQ-016 SHALL act on a write only in the first cycle reg_enable becomes 01 (edge-detected against its registered previous value); held 01 cycles SHALL NOT repeat the write.
REQ-017 CTRL: bits[1:0] mode, bit2 start (write-1, self-clearing, reads 0), bit3 ie.
REQ-018 DATA_IN: read/write; drives core_data_in directly.
REQ-019 DATA_OUT: read-only; loaded only in WRITEBACK; writes ignored.
REQ-020 STATUS: bit0 busy (RO), bit1 done (sticky, W1C), bit2 timeout (sticky, W1C), bit3 ovr (sticky, W1C), bits[5:4] num_err (RO), other bits 0.
REQ-021 prdata SHALL be combinational from paddr whenever reg_enable==10, else 0.
REQ-022 FSM states IDLE, LAUNCH, WAIT, WRITEBACK; busy=1 in every state but IDLE.
REQ-023 IDLE -> LAUNCH on a write to CTRL with bit2=1 and mode!=11; mode==11 with start SHALL set ovr and stay IDLE.
REQ-024 LAUNCH: core_start=1 for exactly this one cycle, timeout counter cleared; -> WAIT.
REQ-025 WAIT: counter increments each cycle; core_done -> WRITEBACK; counter==TIMEOUT-1 without core_done -> IDLE, set timeout.
REQ-026 WRITEBACK: capture core_data_out to DATA_OUT, core_num_err to num_err, set done; -> IDLE (start-to-done latency = 3 cycles + core latency).
REQ-027 While busy, writes to CTRL or DATA_IN SHALL be discarded and set ovr; writes to STATUS still permitted.
REQ-028 core_done outside WAIT SHALL be ignored.
REQ-029 Same-cycle W1C of done and WRITEBACK setting done: set wins; same rule for timeout.
REQ-030 core_mode SHALL be latched from CTRL in LAUNCH and held stable until IDLE.

Reset
REQ-031 On reset: state IDLE, all registers 0, prdata 0, core_start 0, core_mode 00, core_data_in 0, irq 0, edge-detect history 0.
REQ-032 Reset mid-operation SHALL abandon the operation immediately; a later core_done SHALL be ignored.

Structure
REQ-033 Register addresses, STATUS/CTRL bit positions, mode encodings and FSM state encodings SHALL live in a shared package ecc_pkg.
REQ-034 Single module; no sub-module required.

Verification
REQ-035 Write DATA_IN=0xA5A5_0001, CTRL=0x4; core_done 5 cycles after core_start with data_out 0x1234, num_err 1 -> DATA_OUT=0x1234, STATUS=0x12, core_start high exactly 1 cycle.
REQ-036 reg_enable=01 held 4 cycles on CTRL start -> exactly one core_start.
REQ-037 No core_done after start (TIMEOUT=64) -> at WAIT cycle 64 STATUS.timeout=1, busy=0, DATA_OUT unchanged.
REQ-038 Write DATA_IN=0xFFFF while busy -> DATA_IN unchanged, STATUS.ovr=1; W1C 0x8 -> ovr=0.
REQ-039 W1C done in the WRITEBACK cycle with CTRL.ie=1 -> done stays 1, irq=1.
REQ-040 Assert reset in WAIT, then pulse core_done -> state IDLE, STATUS=0, DATA_OUT=0.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg -- shared definitions for the ECC operation sequencer.
//   Register word addresses, CTRL/STATUS bit positions, APB strobe codes,
//   core operation modes and sequencer FSM states.
package ecc_pkg;

   // Register map (word addresses)
   localparam logic [1:0] ADDR_CTRL     = 2'd0;
   localparam logic [1:0] ADDR_DATA_IN  = 2'd1;
   localparam logic [1:0] ADDR_DATA_OUT = 2'd2;
   localparam logic [1:0] ADDR_STATUS   = 2'd3;

   // reg_enable strobe codes
   localparam logic [1:0] EN_WRITE = 2'b01;
   localparam logic [1:0] EN_READ  = 2'b10;

   // CTRL bit positions
   localparam int unsigned CTRL_MODE_LSB = 0;
   localparam int unsigned CTRL_START    = 2;
   localparam int unsigned CTRL_IE       = 3;

   // STATUS bit positions
   localparam int unsigned STAT_BUSY     = 0;
   localparam int unsigned STAT_DONE     = 1;
   localparam int unsigned STAT_TIMEOUT  = 2;
   localparam int unsigned STAT_OVR      = 3;
   localparam int unsigned STAT_NERR_LSB = 4;

   typedef enum logic [1:0] {
      MODE_ENCODE  = 2'b00,
      MODE_DECODE  = 2'b01,
      MODE_CORRECT = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT      = 2'd2,
      ST_WRITEBACK = 2'd3
   } state_e;

endpackage

// File: rtl/ecc_op_sequencer.sv
// ecc_op_sequencer -- APB-style register front end that launches one ECC
// core operation at a time and collects its result.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   reg_enable, paddr   access strobe (01 write / 10 read) and word address
//   pwdata, prdata      write data in, combinational read data out
//   core_start          one-cycle start pulse to the core
//   core_mode           operation for the core, stable for the whole operation
//   core_data_in        operand (the DATA_IN register)
//   core_done           one-cycle completion pulse, qualifies the two below
//   core_data_out       core result
//   core_num_err        error count reported by the core
//   irq                 STATUS.done AND CTRL.ie
module ecc_op_sequencer
   import ecc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            reg_enable,
   input  logic [1:0]            paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  core_start,
   output logic [1:0]            core_mode,
   output logic [DATA_WIDTH-1:0] core_data_in,
   input  logic                  core_done,
   input  logic [DATA_WIDTH-1:0] core_data_out,
   input  logic [1:0]            core_num_err,
   output logic                  irq
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_e                state, state_n;
   logic [1:0]            prev_en;
   logic [CNT_W-1:0]      cnt;
   logic [1:0]            ctrl_mode, mode_lat;
   logic                  ctrl_ie;
   logic [DATA_WIDTH-1:0] data_in, data_out, res_data;
   logic [1:0]            num_err, res_err;
   logic                  st_done, st_timeout, st_ovr;
   logic                  busy, wr_pulse, start_ok, tmo;

   // A write acts only on the rising edge of the 01 strobe.
   assign wr_pulse = (reg_enable == EN_WRITE) && (prev_en != EN_WRITE);
   assign busy     = (state != ST_IDLE);
   assign start_ok = wr_pulse && (paddr == ADDR_CTRL) && pwdata[CTRL_START]
                     && (pwdata[CTRL_MODE_LSB +: 2] != MODE_RSVD);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      core_start = 1'b0;
      tmo        = 1'b0;
      case (state)
         ST_IDLE:      if (start_ok) state_n = ST_LAUNCH;
         ST_LAUNCH: begin
            core_start = 1'b1;
            state_n    = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_done) state_n = ST_WRITEBACK;
            else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               state_n = ST_IDLE;
               tmo     = 1'b1;
            end
         end
         ST_WRITEBACK: state_n = ST_IDLE;
         default:      state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_en    <= '0;
         cnt        <= '0;
         ctrl_mode  <= '0;
         ctrl_ie    <= 1'b0;
         mode_lat   <= '0;
         data_in    <= '0;
         data_out   <= '0;
         res_data   <= '0;
         res_err    <= '0;
         num_err    <= '0;
         st_done    <= 1'b0;
         st_timeout <= 1'b0;
         st_ovr     <= 1'b0;
      end else begin
         prev_en <= reg_enable;

         if (state == ST_LAUNCH) begin
            cnt      <= '0;
            mode_lat <= ctrl_mode;
         end else if (state == ST_WAIT) begin
            cnt <= cnt + 1'b1;
         end

         // core_done is only guaranteed valid for one cycle, so the result is
         // held here and committed to DATA_OUT in WRITEBACK.
         if ((state == ST_WAIT) && core_done) begin
            res_data <= core_data_out;
            res_err  <= core_num_err;
         end

         if (wr_pulse) begin
            case (paddr)
               ADDR_CTRL: begin
                  if (busy) st_ovr <= 1'b1;
                  else begin
                     ctrl_mode <= pwdata[CTRL_MODE_LSB +: 2];
                     ctrl_ie   <= pwdata[CTRL_IE];
                     if (pwdata[CTRL_START] && (pwdata[CTRL_MODE_LSB +: 2] == MODE_RSVD))
                        st_ovr <= 1'b1;
                  end
               end
               ADDR_DATA_IN: begin
                  if (busy) st_ovr <= 1'b1;
                  else      data_in <= pwdata;
               end
               ADDR_STATUS: begin
                  if (pwdata[STAT_DONE])    st_done    <= 1'b0;
                  if (pwdata[STAT_TIMEOUT]) st_timeout <= 1'b0;
                  if (pwdata[STAT_OVR])     st_ovr     <= 1'b0;
               end
               default: ;
            endcase
         end

         // Placed after the W1C handling so a same-cycle set wins.
         if (state == ST_WRITEBACK) begin
            data_out <= res_data;
            num_err  <= res_err;
            st_done  <= 1'b1;
         end
         if (tmo) st_timeout <= 1'b1;
      end
   end

   // mode_lat is only written at the end of LAUNCH, so CTRL feeds core_mode
   // directly during LAUNCH to keep it valid alongside core_start.
   assign core_mode    = (state == ST_LAUNCH) ? ctrl_mode : mode_lat;
   assign core_data_in = data_in;
   assign irq          = st_done & ctrl_ie;

   always_comb begin
      prdata = '0;
      if (reg_enable == EN_READ) begin
         case (paddr)
            ADDR_CTRL: begin
               prdata[CTRL_MODE_LSB +: 2] = ctrl_mode;
               prdata[CTRL_IE]            = ctrl_ie;
            end
            ADDR_DATA_IN:  prdata = data_in;
            ADDR_DATA_OUT: prdata = data_out;
            ADDR_STATUS: begin
               prdata[STAT_BUSY]          = busy;
               prdata[STAT_DONE]          = st_done;
               prdata[STAT_TIMEOUT]       = st_timeout;
               prdata[STAT_OVR]           = st_ovr;
               prdata[STAT_NERR_LSB +: 2] = num_err;
            end
            default: prdata = '0;
         endcase
      end
   end

endmodule
